// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 scancode front end.
// FSM states, Set-2 prefix bytes, controller responses, event struct.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GOT_E0,
    GOT_F0,
    GOT_E0F0,
    SKIP_E1
  } ps2_state_e;

  localparam logic [7:0] PS2_EXT    = 8'hE0;
  localparam logic [7:0] PS2_BRK    = 8'hF0;
  localparam logic [7:0] PS2_PAUSE  = 8'hE1;
  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_BAT    = 8'hAA;
  localparam logic [7:0] PS2_ECHO   = 8'hEE;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERR0   = 8'h00;
  localparam logic [7:0] PS2_ERR1   = 8'hFF;

  localparam logic [2:0] PAUSE_SKIP = 3'd7;

  typedef struct packed {
    logic       ext;
    logic       brk;
    logic [7:0] code;
  } ps2_evt_t;

  function automatic logic is_resp(input logic [7:0] b);
    return (b == PS2_ACK) || (b == PS2_BAT) ||
           (b == PS2_ECHO) || (b == PS2_RESEND) ||
           (b == PS2_ERR0) || (b == PS2_ERR1);
  endfunction

endpackage

// File: rtl/ps2_evt_fifo.sv
// Synchronous show-ahead FIFO of ps2_evt_t; dout reads 0 while empty.
// Ports: clk, reset, push/din, pop/dout, count, full, empty.
module ps2_evt_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  ps2_evt_t         din,
  input  logic             pop,
  output ps2_evt_t         dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  ps2_evt_t         mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             wr_en;
  logic             rd_en;

  assign empty = (count == '0);
  assign full  = (count == CNT_W'(DEPTH));
  assign rd_en = pop & ~empty;
  // A pop frees the slot, so a full FIFO still accepts a push
  assign wr_en = push & (~full | rd_en);
  assign dout  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ps2_scancode_fifo.sv
// PS/2 Set-2 parser (E0/F0/E1) feeding a key-event FIFO, with last-byte
// register and sticky overflow. Optional TYPEMATIC_FILTER_EN drops repeats.
// Ports: CLOCK_50, reset, rx_data/rx_valid in; evt_* pop side; ovf_clr,
// overflow, last_code.
module ps2_scancode_fifo
  import ps2_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  input  logic             evt_ready,
  input  logic             ovf_clr,
  output logic             evt_valid,
  output logic [7:0]       evt_code,
  output logic             evt_ext,
  output logic             evt_break,
  output logic [CNT_W-1:0] evt_count,
  output logic             overflow,
  output logic [7:0]       last_code
);

  ps2_state_e state, nxt;
  logic [2:0] skip, skip_nxt;
  ps2_evt_t   dec, head;
  logic       dec_push;
  logic       evt_push;
  logic       full, empty, pop;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state <= IDLE;
      skip  <= '0;
    end else begin
      state <= nxt;
      skip  <= skip_nxt;
    end
  end

  always_comb begin
    nxt      = state;
    skip_nxt = skip;
    dec_push = 1'b0;
    dec      = '{ext: 1'b0, brk: 1'b0, code: rx_data};
    if (rx_valid) begin
      unique case (state)
        IDLE: begin
          unique case (1'b1)
            rx_data == PS2_EXT: nxt = GOT_E0;
            rx_data == PS2_BRK: nxt = GOT_F0;
            rx_data == PS2_PAUSE: begin
              nxt      = SKIP_E1;
              skip_nxt = PAUSE_SKIP;
              dec_push = 1'b1;
            end
            is_resp(rx_data): ;
            default: dec_push = 1'b1;
          endcase
        end
        GOT_E0: begin
          if (rx_data == PS2_BRK) begin
            nxt = GOT_E0F0;
          end else if (rx_data != PS2_EXT) begin
            dec_push = 1'b1;
            dec.ext  = 1'b1;
            nxt      = IDLE;
          end
        end
        GOT_F0: begin
          dec_push = 1'b1;
          dec.brk  = 1'b1;
          nxt      = IDLE;
        end
        GOT_E0F0: begin
          dec_push = 1'b1;
          dec.ext  = 1'b1;
          dec.brk  = 1'b1;
          nxt      = IDLE;
        end
        SKIP_E1: begin
          skip_nxt = skip - 3'd1;
          if (skip == 3'd1) nxt = IDLE;
        end
        default: nxt = IDLE;
      endcase
    end
  end

`ifdef TYPEMATIC_FILTER_EN
  logic [511:0] held;
  logic [8:0]   idx;
  logic         dec_pause;
  logic         repeat_make;

  assign idx         = {dec.ext, dec.code};
  assign dec_pause   = (state == IDLE) & (rx_data == PS2_PAUSE);
  assign repeat_make = dec_push & ~dec.brk & ~dec_pause & held[idx];
  assign evt_push    = dec_push & ~repeat_make;

  // Map follows the decoded stream, independent of FIFO acceptance
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      held <= '0;
    end else if (dec_push & ~dec_pause) begin
      held[idx] <= ~dec.brk;
    end
  end
`else
  assign evt_push = dec_push;
`endif

  assign pop = evt_valid & evt_ready;

  ps2_evt_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (CLOCK_50),
    .reset (reset),
    .push  (evt_push),
    .din   (dec),
    .pop   (pop),
    .dout  (head),
    .count (evt_count),
    .full  (full),
    .empty (empty)
  );

  assign evt_valid = ~empty;
  assign evt_code  = head.code;
  assign evt_ext   = head.ext;
  assign evt_break = head.brk;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      overflow  <= 1'b0;
      last_code <= 8'h00;
    end else begin
      if (rx_valid) last_code <= rx_data;
      if (evt_push & full & ~pop) overflow <= 1'b1;
      else if (ovf_clr)           overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_scancode_fifo.sv
// Scoreboard bench for ps2_scancode_fifo: byte-stream reference parser,
// queue-based FIFO model, per-cycle monitor on the falling edge.
module tb_ps2_scancode_fifo;

  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       rx_data;
  logic             rx_valid;
  logic             evt_ready;
  logic             ovf_clr;
  logic             evt_valid;
  logic [7:0]       evt_code;
  logic             evt_ext;
  logic             evt_break;
  logic [CNT_W-1:0] evt_count;
  logic             overflow;
  logic [7:0]       last_code;

  always #5 clk = ~clk;

  ps2_scancode_fifo #(.DEPTH(DEPTH)) dut (
    .CLOCK_50  (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .evt_ready (evt_ready),
    .ovf_clr   (ovf_clr),
    .evt_valid (evt_valid),
    .evt_code  (evt_code),
    .evt_ext   (evt_ext),
    .evt_break (evt_break),
    .evt_count (evt_count),
    .overflow  (overflow),
    .last_code (last_code)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference parser: {has, ext, brk, code}
  int   skip_left;
  bit   pend_ext;
  bit   pend_brk;
  bit   held [512];

  logic [10:0] pend_q [$];
  logic [9:0]  exp_q [$];
  bit          m_ovf;
  logic [7:0]  m_last;
  bit          armed;

  function automatic void model_reset();
    skip_left = 0;
    pend_ext  = 0;
    pend_brk  = 0;
    foreach (held[i]) held[i] = 0;
  endfunction

  function automatic logic [10:0] decode(input logic [7:0] b);
    logic [10:0] r;
    r = '0;
    if (skip_left > 0) begin
      skip_left--;
      return r;
    end
    if (pend_brk) begin
      r = {1'b1, pend_ext, 1'b1, b};
      pend_ext = 0;
      pend_brk = 0;
    end else if (b == 8'hF0) begin
      pend_brk = 1;
    end else if (b == 8'hE0) begin
      pend_ext = 1;
    end else if (pend_ext) begin
      r = {1'b1, 1'b1, 1'b0, b};
      pend_ext = 0;
    end else if (b == 8'hE1) begin
      skip_left = 7;
      return {1'b1, 2'b00, b};
    end else if (!(b inside {8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF})) begin
      r = {1'b1, 2'b00, b};
    end
`ifdef TYPEMATIC_FILTER_EN
    if (r[10]) begin
      if (r[8]) held[{r[9], r[7:0]}] = 0;
      else if (held[{r[9], r[7:0]}]) r = '0;
      else held[{r[9], r[7:0]}] = 1;
    end
`endif
    return r;
  endfunction

  task automatic cyc(input bit v, input logic [7:0] b, input bit rdy,
                     input bit clr, input bit rst);
    @(posedge clk);
    #1;
    reset     = rst;
    rx_valid  = v;
    rx_data   = b;
    evt_ready = rdy;
    ovf_clr   = clr;
    if (rst) model_reset();
    if (v) pend_q.push_back(rst ? 11'd0 : decode(b));
  endtask

  task automatic send(input logic [7:0] b, input bit rdy);
    cyc(1'b1, b, rdy, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, rdy, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: compare current outputs, then apply this cycle's inputs
  initial begin
    logic [10:0] e;
    bit          pop;
    bit          set;
    armed  = 0;
    m_ovf  = 0;
    m_last = 8'h00;
    forever begin
      @(negedge clk);
      if (armed) begin
        chk("evt_valid", 32'(evt_valid), 32'(exp_q.size() != 0));
        chk("evt_count", 32'(evt_count), 32'(exp_q.size()));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("last_code", 32'(last_code), 32'(m_last));
        if (exp_q.size() != 0)
          chk("head", 32'({evt_ext, evt_break, evt_code}), 32'(exp_q[0]));
        else
          chk("empty_head", 32'({evt_ext, evt_break, evt_code}), 32'd0);
      end
      e = '0;
      if (rx_valid) begin
        if (pend_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL pend_q: got empty expected entry at %0t", $time);
        end else begin
          e = pend_q.pop_front();
        end
      end
      if (reset) begin
        exp_q.delete();
        m_ovf  = 0;
        m_last = 8'h00;
        armed  = 1;
      end else if (armed) begin
        pop = (exp_q.size() != 0) && evt_ready;
        set = 0;
        if (rx_valid) m_last = rx_data;
        if (pop) void'(exp_q.pop_front());
        if (e[10]) begin
          if (exp_q.size() >= DEPTH) set = 1;
          else exp_q.push_back(e[9:0]);
        end
        if (set) m_ovf = 1;
        else if (ovf_clr) m_ovf = 0;
      end
    end
  end

  initial begin
    logic [7:0] resp [6];
    logic [7:0] b;
    int         r;
    resp = '{8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF};
    reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    evt_ready = 1'b0; ovf_clr = 1'b0;
    model_reset();
    do_reset();

    // make/break, then hold to observe latency and head
    send(8'h1C, 1'b0); send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    idle(2, 1'b0); idle(4, 1'b1);

    // extended keys and repeated E0
    send(8'hE0, 1'b1); send(8'h75, 1'b1);
    send(8'hE0, 1'b1); send(8'hF0, 1'b1); send(8'h75, 1'b1);
    send(8'hE0, 1'b1); send(8'hE0, 1'b1); send(8'h75, 1'b1);
    idle(3, 1'b1);

    // Pause sequence yields a single event
    foreach (resp[i]) ;
    send(8'hE1, 1'b0); send(8'h14, 1'b0); send(8'h77, 1'b0);
    send(8'hE1, 1'b0); send(8'hF0, 1'b0); send(8'h14, 1'b0);
    send(8'hF0, 1'b0); send(8'h77, 1'b0); send(8'h1C, 1'b0);
    idle(2, 1'b0); idle(4, 1'b1);

    // overflow: nine makes into an 8-deep FIFO
    do_reset();
    for (int i = 0; i < 9; i++) send(8'h15 + 8'(i), 1'b0);
    idle(2, 1'b0);
    send(8'h2A, 1'b1);
    cyc(1'b1, 8'h2B, 1'b0, 1'b1, 1'b0);
    idle(1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    idle(2, 1'b0);
    idle(DEPTH + 2, 1'b1);

    // reset discards a pending prefix; reset beats rx_valid
    send(8'hE0, 1'b1);
    cyc(1'b1, 8'h33, 1'b1, 1'b0, 1'b1);
    send(8'h75, 1'b1);
    send(8'hAA, 1'b1);
    idle(3, 1'b1);

    // typematic repeats
    do_reset();
    send(8'h1C, 1'b1); send(8'h1C, 1'b1); send(8'h1C, 1'b1);
    send(8'hF0, 1'b1); send(8'h1C, 1'b1); send(8'h1C, 1'b1);
    idle(3, 1'b1);

    // randomized traffic
    for (int n = 0; n < 4000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 8)       b = 8'hE0;
      else if (r < 16) b = 8'hF0;
      else if (r < 18) b = 8'hE1;
      else if (r < 24) b = resp[$urandom_range(0, 5)];
      else if (r < 80) b = 8'h10 + 8'($urandom_range(0, 15));
      else             b = 8'($urandom_range(0, 255));
      cyc(($urandom_range(0, 99) < 70), b, ($urandom_range(0, 99) < 55),
          ($urandom_range(0, 99) < 3), ($urandom_range(0, 999) < 4));
    end

    cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(DEPTH + 3, 1'b1);
    chk("drained", 32'(evt_valid), 32'd0);
    chk("pend_left", 32'(pend_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ps2_scancode_fifo.md
Name: ps2_scancode_fifo

Overview:
Second-generation PS/2 keyboard front end, sitting between PS2_Controller (received_data / received_data_en) and game logic.
Parses raw Set-2 bytes (E0 extended prefix, F0 break prefix, E1 Pause sequence) into complete key events. Queues the events in a parametrised FIFO with a valid/ready pop handshake.
Keeps the legacy last-byte register and adds a sticky overflow flag.

Parameters:
DEPTH, 8, FIFO entries; power of two, >= 2
CNT_W, $clog2(DEPTH+1), width of evt_count (derived; not overridden)

Ports:
CLOCK_50  in  1  system clock; all logic on rising edge
reset  in  1  synchronous, active-high reset
rx_data  in  8  byte from PS2_Controller received_data
rx_valid  in  1  one-cycle strobe from received_data_en
evt_ready  in  1  consumer pops head event when evt_valid is also high
ovf_clr  in  1  clears overflow
evt_valid  out  1  FIFO not empty
evt_code  out  8  head event scancode
evt_ext  out  1  head event was E0-prefixed
evt_break  out  1  head event is a release
evt_count  out  CNT_W  entries held, 0..DEPTH
overflow  out  1  sticky: an event was dropped because the FIFO was full
last_code  out  8  last raw byte received, prefixes included

Behaviour:
- Clock and reset: one clock, CLOCK_50. Reset is synchronous and active-high, named reset.
- Reset values: FSM=IDLE, FIFO empty, evt_valid=0, evt_count=0, overflow=0, last_code=8'h00, skip counter=0. evt_code/ext/break read 0 while empty.
  - Reset mid-sequence (e.g. after E0) discards the partial prefix.
  - Reset beats rx_valid and pop in the same cycle.
- last_code: loads rx_data on every rx_valid, regardless of FSM state.
- Parser FSM advances only on rx_valid:
  - IDLE:
    - E0 -> GOT_E0; F0 -> GOT_F0.
    - E1 -> SKIP_E1 with skip=7; push {code=E1, ext=0, brk=0}.
    - FA, AA, EE, FE, 00, FF are controller responses: discarded, stay IDLE.
    - Any other byte: push {code, 0, 0}, stay IDLE.
  - GOT_E0: F0 -> GOT_E0F0; E0 -> stay; other: push {code, 1, 0} -> IDLE.
  - GOT_F0: any byte: push {code, 0, 1} -> IDLE.
  - GOT_E0F0: any byte: push {code, 1, 1} -> IDLE.
  - SKIP_E1: skip decrements per byte; the byte that takes skip to 0 returns to IDLE; nothing pushed.
- Push timing: decode is combinational on rx_data. The write happens at the edge ending the rx_valid cycle. evt_valid rises on the next cycle (latency 1).
- FIFO:
  - Show-ahead: head fields are valid whenever evt_valid=1.
  - Pop = evt_valid & evt_ready. evt_ready while empty has no effect.
  - Push + pop same cycle: both occur and evt_count is unchanged. This holds when full (push accepted) and when count=1.
  - Push while full without pop: the event is dropped and overflow is set. FIFO contents are unchanged.
  - Pointers are log2(DEPTH) bits and wrap naturally. evt_count is tracked separately.
- overflow: cleared by ovf_clr. A set in the same cycle as ovf_clr wins.

Optional Feature:
- TYPEMATIC_FILTER_EN defined:
  - A 512-bit held map, indexed by {ext, code}, is cleared on reset.
  - A make event for a key whose bit is already set is suppressed: no push, no overflow. Otherwise the make sets the bit.
  - A break clears the bit and is always pushed.
  - The E1 Pause event is never filtered.
  - The held map updates even when the push is dropped for overflow.
- Undefined: every make event is queued, including typematic repeats.

Decomposition:
- Package ps2_pkg holds:
  - FSM state enum (IDLE, GOT_E0, GOT_F0, GOT_E0F0, SKIP_E1).
  - Byte constants PS2_EXT=8'hE0, PS2_BRK=8'hF0, PS2_PAUSE=8'hE1, and the response bytes.
  - Packed struct ps2_evt_t {ext, brk, code[7:0]} (10 bits).
  - PAUSE_SKIP=7.
- Sub-module ps2_evt_fifo: generic synchronous show-ahead FIFO of ps2_evt_t, parameter DEPTH, with push/pop/count/full/empty.

Test Plan:
- Reset, then bytes 1C, F0 1C -> two events {1C,0,0} then {1C,0,1}; last_code=1C; evt_valid rises 1 cycle after the first rx_valid.
- E0 75, E0 F0 75 -> {75,1,0}, {75,1,1}; E0 E0 75 -> single {75,1,0}.
- E1 14 77 E1 F0 14 F0 77 -> exactly one event {E1,0,0}; a following 1C yields {1C,0,0}.
- DEPTH=8, evt_ready=0, 9 makes -> evt_count=8, overflow=1, 9th lost. Then push and pop in the same cycle -> count stays 8. ovf_clr -> overflow=0.
- Byte E0, then reset pulse, then 75 -> {75,0,0} (prefix discarded). Byte AA -> no event, last_code=AA.
- With TYPEMATIC_FILTER_EN: 1C 1C 1C F0 1C 1C -> events make, break, make only. Without it: 4 makes + 1 break.
